// File: rtl/vga_frame_monitor.sv
// Receive-side VGA timing checker: locks onto the sync structure, flags timing and
// blanking violations, and publishes a per-frame pixel checksum and frame count.
module vga_frame_monitor #(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned H_FP            = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BP            = 48,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned V_FP            = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BP            = 33,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned RGB_W           = 12
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic             vga_hsync,
  input  logic             vga_vsync,
  input  logic [RGB_W-1:0] vga_rgb,
  output logic             locked,
  output logic             frame_done,
  output logic [15:0]      frame_crc,
  output logic [15:0]      frame_count,
  output logic             h_err,
  output logic             v_err,
  output logic             blank_err
);

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_LO    = H_SYNC + H_BP;
  localparam int unsigned H_HI    = H_LO + H_ACTIVE;
  localparam int unsigned V_LO    = V_SYNC + V_BP;
  localparam int unsigned V_HI    = V_LO + V_ACTIVE;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t           state;
  logic             hsync_s;
  logic             vsync_s;
  logic [RGB_W-1:0] rgb_s;
  logic             hs_act_q;
  logic             vs_act_q;
  logic [CNT_W-1:0] h_q;
  logic [CNT_W-1:0] v_q;
  logic [15:0]      acc;

  logic             hs_act;
  logic             vs_act;
  logic             h_edge;
  logic             v_edge;
  logic [CNT_W-1:0] h_cur;
  logic [CNT_W-1:0] v_cur;
  logic             in_active;
  logic             h_bad;
  logic             v_bad;
  logic             blank_hit;

  // Position of the sample currently in the sample stage; h_q/v_q hold the previous one.
  assign hs_act    = SYNC_ACTIVE_LOW ? ~hsync_s : hsync_s;
  assign vs_act    = SYNC_ACTIVE_LOW ? ~vsync_s : vsync_s;
  assign h_edge    = hs_act & ~hs_act_q;
  assign v_edge    = vs_act & ~vs_act_q;
  assign h_cur     = h_edge ? '0 : ((h_q == CNT_MAX) ? h_q : h_q + 1'b1);
  assign v_cur     = v_edge ? '0 : (h_edge ? ((v_q == CNT_MAX) ? v_q : v_q + 1'b1) : v_q);
  assign in_active = (h_cur >= CNT_W'(H_LO)) && (h_cur < CNT_W'(H_HI)) &&
                     (v_cur >= CNT_W'(V_LO)) && (v_cur < CNT_W'(V_HI));
  assign h_bad     = h_edge && (h_q != CNT_W'(H_TOTAL - 1));
  assign v_bad     = v_edge && ((v_q != CNT_W'(V_TOTAL - 1)) || !h_edge);
  assign blank_hit = !in_active && (rgb_s != '0);

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      // Sample stage resets to "sync active" so no edge is seen until a real transition.
      hsync_s     <= ~SYNC_ACTIVE_LOW;
      vsync_s     <= ~SYNC_ACTIVE_LOW;
      rgb_s       <= '0;
      hs_act_q    <= 1'b1;
      vs_act_q    <= 1'b1;
      h_q         <= '0;
      v_q         <= '0;
      acc         <= '0;
      state       <= SEARCH;
      locked      <= 1'b0;
      frame_done  <= 1'b0;
      frame_crc   <= '0;
      frame_count <= '0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      blank_err   <= 1'b0;
    end else begin
      hsync_s    <= vga_hsync;
      vsync_s    <= vga_vsync;
      rgb_s      <= vga_rgb;
      hs_act_q   <= hs_act;
      vs_act_q   <= vs_act;
      h_q        <= h_cur;
      v_q        <= v_cur;
      frame_done <= 1'b0;

      if (v_edge)
        acc <= '0;
      else if (in_active)
        acc <= {acc[14:0], acc[15]} ^ 16'(rgb_s);

      case (state)
        SEARCH: begin
          if (v_edge) state <= ALIGN;
        end
        ALIGN: begin
          if (h_bad || v_bad) begin
            if (h_bad) h_err <= 1'b1;
            if (v_bad) v_err <= 1'b1;
            state <= SEARCH;
          end else if (v_edge) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (blank_hit) blank_err <= 1'b1;
          if (h_bad || v_bad) begin
            if (h_bad) h_err <= 1'b1;
            if (v_bad) v_err <= 1'b1;
            state  <= SEARCH;
            locked <= 1'b0;
          end else if (v_edge) begin
            frame_crc   <= acc;
            frame_count <= frame_count + 16'd1;
            frame_done  <= 1'b1;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/vga_frame_monitor.md
# vga_frame_monitor

Receive-side checker for the VGA output: it samples the hsync, vsync and RGB signals the display path drives, and locks onto the 640x480 frame structure. It verifies horizontal and vertical timing, checks that blanking is respected, and publishes a per-frame pixel checksum and frame count. It sits beside `top` in the simulation bench, fed from the `vgaData` fields, and can also be instantiated on-chip as a self-check.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync, back porch (H_TOTAL = 800)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync, back porch (V_TOTAL = 525)
- SYNC_ACTIVE_LOW, 1, 1 = a sync is asserted when its level is low
- RGB_W, 12, RGB bus width (must be ≤ 16)

Ports:
- vga_clk  in  1  pixel clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-high
- vga_hsync  in  1  horizontal sync from the display path
- vga_vsync  in  1  vertical sync from the display path
- vga_rgb  in  RGB_W  pixel colour
- locked  out  1  frame structure verified and being tracked
- frame_done  out  1  one-cycle pulse when a locked frame completes
- frame_crc  out  16  checksum of the last completed locked frame
- frame_count  out  16  number of completed locked frames; wraps from FFFF to 0000
- h_err / v_err / blank_err  out  1 each  sticky error flags

## Operation
- Inputs are registered once (the sample stage). All edge detection and checks use the sampled values.
- A leading edge is a transition of a sync signal from inactive to active, per SYNC_ACTIVE_LOW.
- Line position: the sample carrying the hsync leading edge is h = 0. Each later sample increments h, saturating at 2047.
- Line index: the sample carrying the vsync leading edge is v = 0. Each subsequent hsync leading edge increments v.
- The active window is H_SYNC+H_BP ≤ h < H_SYNC+H_BP+H_ACTIVE (144..783) and V_SYNC+V_BP ≤ v < V_SYNC+V_BP+V_ACTIVE (35..514).
- Checksum accumulator: on each active sample, acc ← rotl1(acc) ^ zero-extended rgb. On a vsync leading edge, acc is cleared.
- State machine:
  - SEARCH: wait for a vsync leading edge, then go to ALIGN.
  - ALIGN: if a full frame completes with no h/v error, go to LOCKED at the next vsync leading edge. On any error, return to SEARCH.
  - LOCKED: on each vsync leading edge, load frame_crc ← acc (the final value including that frame), increment frame_count, and pulse frame_done.
- Line check (ALIGN/LOCKED): at an hsync leading edge, the pre-edge h must equal H_TOTAL−1. Otherwise set h_err and go to SEARCH.
- Frame check (ALIGN/LOCKED): at a vsync leading edge, the pre-edge v must equal V_TOTAL−1, and an hsync leading edge must occur in the same sample. Otherwise set v_err and go to SEARCH without publishing.
- When hsync and vsync edges coincide, the vsync rule wins: v becomes 0 rather than incrementing.
- Blank check (LOCKED only): a nonzero rgb outside the active window sets blank_err. This causes no state change.
- locked = 1 exactly while in LOCKED.
- Error flags stay set until reset.

## Timing
- Reset: every output is 0, all counters and the accumulator are 0, and the state is SEARCH.
- Reset asserted mid-frame aborts immediately. Relock then requires a vsync edge plus one clean frame.
- Latency: a sync input edge presented before rising edge N is sampled at N. frame_done, frame_crc, frame_count, locked and the error flags update at edge N+1.
- Lock timing with a clean source:
  - locked rises at the 2nd vsync leading edge after reset.
  - The first frame_done occurs at the 3rd edge.
- frame_done pulses exactly 1 cycle, once per V_TOTAL·H_TOTAL = 420000 cycles.

## Test plan
- Ideal 640x480 generator with rgb = 0 everywhere → locked = 1 after the 2nd vsync edge; frame_done every 420000 cycles; frame_crc = 16'h0000; no error flags set.
- Generator with rgb = 12'hABC at active pixel (0,0), 12'h123 at active pixel (639,479), and 0 elsewhere → frame_crc = 16'h047D for each locked frame. With only the (0,0) pixel present → frame_crc = 16'h055E.
- One line shortened to 799 samples while locked → h_err = 1 and locked = 0 at that line's next hsync edge; relock after 1 clean frame with h_err still 1; frame_count holds during the outage.
- Frame with 524 lines → v_err = 1 and locked falls at that vsync edge; no frame_done for that frame.
- rgb = 12'hFFF at h = 10 (in hsync) while locked → blank_err = 1; locked stays 1; frame_crc is unchanged by that sample.
- Reset pulse mid-frame after 3 locked frames → all outputs 0 during reset; frame_count restarts at 0; first frame_done occurs at the 3rd post-reset vsync edge.
